// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared types and default widths for the icache/dcache memory arbiter
package cache_mem_arbiter_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RECOVER} arb_state_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;
endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one cacheline memory path between icache and dcache
//   clk, rst (sync, active-low)
//   icache: i_read, i_address -> i_rdata, i_resp
//   dcache: d_read, d_write, d_address, d_wdata -> d_rdata, d_resp
//   memory: m_read, m_write, m_address, m_wdata -> adaptor; m_rdata, m_resp <- adaptor
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);
    arb_state_t state, state_next;
    arb_src_t last_grant;
    logic cmd_write, busy, i_done, d_done, any_req, pick_d;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LINE_W-1:0] cmd_wdata, i_line, d_line;
    assign any_req = i_read | d_read | d_write;
    // dcache wins when alone, or on a tie when icache had the previous grant
    assign pick_d = (d_read | d_write) & (~i_read | (last_grant == SRC_I));
    assign busy = (state == GRANT_I) | (state == GRANT_D);
    assign i_done = (state == GRANT_I) & m_resp;
    assign d_done = (state == GRANT_D) & m_resp;
    assign m_read = busy & ~cmd_write;
    assign m_write = busy & cmd_write;
    assign m_address = cmd_addr;
    assign m_wdata = cmd_wdata;
    assign i_resp = i_done;
    assign d_resp = d_done;
    assign i_rdata = i_done ? m_rdata : i_line;
    assign d_rdata = d_done ? m_rdata : d_line;
    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = any_req ? (pick_d ? GRANT_D : GRANT_I) : IDLE;
        else if (state == RECOVER)
            state_next = IDLE;
        else
            state_next = m_resp ? RECOVER : state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= SRC_D;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            i_line     <= '0;
            d_line     <= '0;
        end else begin
            state <= state_next;
            if (i_done) i_line <= m_rdata;
            if (d_done) d_line <= m_rdata;
            // the command is frozen here so requester-side changes cannot disturb the burst;
            // a simultaneous d_read/d_write is resolved as a write
            if (state == IDLE && any_req) begin
                last_grant <= pick_d ? SRC_D : SRC_I;
                cmd_write  <= pick_d & d_write;
                cmd_addr   <= pick_d ? d_address : i_address;
                cmd_wdata  <= pick_d ? d_wdata : '0;
            end
        end
    end
endmodule
